uart_cmd_rcv: RTL and testbench
===============================

// Module: uart_cmd_rcv
// PURPOSE
//   Platform-side end of the rider-to-Segway UART command link. Deserializes 8N1
//   frames on RX into rx_data/rdy, then runs a power authorization FSM on the bytes:
//   'g' (8'h67) powers up, 's' (8'h73) powers down once the rider has stepped off.
//   Sits between the RX pin and the balance/steer control enable (pwr_up).
// PARAMETERS
//   BAUD_DIV  2604  clk cycles per bit (50 MHz / 19200 baud); >= 8
//   GO_CMD    8'h67 byte that requests power-up
//   STOP_CMD  8'h73 byte that requests power-down
// PORTS
//   clk        in   1  system clock, all flops posedge
//   RST_n      in   1  asynchronous active-low reset
//   RX         in   1  serial input, idle high, asynchronous to clk
//   clr_rdy    in   1  consumer acknowledges rx_data; clears rdy
//   rider_off  in   1  high when load cells report no rider
//   rx_data    out  8  last received byte, held until next frame completes
//   rdy        out  1  new byte available
//   pwr_up     out  1  power authorized to motor/balance control
//   frm_err    out  1  one-cycle pulse on bad stop bit (FRAME_CHK_EN only)
// BEHAVIOUR
//   Reset: rx_data=8'h00, rdy=0, pwr_up=0, frm_err=0; RX sync flops preset to 1;
//     RX FSM in IDLE, auth FSM in OFF. Reset mid-frame abandons the frame.
//   RX is double-flopped before any use; all decisions use the 2nd flop (rx_s).
//   RX FSM: IDLE -> START on rx_s==0; baud_cnt loaded with BAUD_DIV/2, bit_cnt=0.
//     START: at baud_cnt==0 sample rx_s; if 1 (glitch) -> IDLE, no rdy; else
//       -> RECV, reload baud_cnt=BAUD_DIV.
//     RECV: at each baud_cnt==0 shift rx_s into shift reg LSB-first, bit_cnt++,
//       reload BAUD_DIV. After 8 data bits -> STOP; at next mid-bit sample stop
//       bit, latch shift[7:0] into rx_data, set rdy next cycle, -> IDLE.
//   Latency: rdy rises 9*BAUD_DIV + BAUD_DIV/2 + 3 (+/-1) cycles after RX falls.
//   rdy: cleared by clr_rdy or on entering START. Frame completion coinciding with
//     clr_rdy leaves rdy=1 (set wins). rdy held indefinitely without clr_rdy;
//     a later frame overwrites rx_data (no overrun flag).
//   byte_vld: internal 1-cycle strobe on the cycle rdy is set; drives auth FSM,
//     independent of clr_rdy.
//   Auth FSM (registered pwr_up, changes cycle after byte_vld):
//     OFF:     byte_vld & GO_CMD -> ON (pwr_up=1). All else ignored.
//     ON:      byte_vld & STOP_CMD -> rider_off ? OFF : PEND_OFF.
//     PEND_OFF: pwr_up stays 1; rider_off -> OFF (pwr_up=0 next cycle);
//              byte_vld & GO_CMD -> ON. Other bytes ignored in every state.
//   Simultaneous STOP_CMD and rider_off in ON: go straight to OFF.
// CONFIGURATION
//   FRAME_CHK_EN defined: stop bit sampled 0 -> rx_data unchanged, rdy not set,
//     no byte_vld, frm_err pulses 1 cycle, FSM -> IDLE (waits for rx_s==1 first).
//   FRAME_CHK_EN undefined: stop bit not checked, every frame delivered;
//     frm_err tied 0.
// TESTING (bench uses BAUD_DIV=32, drives RX through a UART_tx model)
//   Send 8'hA5 -> rx_data=8'hA5, rdy=1 within 9*32+16+4 cycles of start edge;
//     pulse clr_rdy -> rdy=0 next cycle; pwr_up stays 0.
//   Send 'g' -> pwr_up=1; send 's' with rider_off=0 -> pwr_up still 1; raise
//     rider_off -> pwr_up=0 on following cycle.
//   rider_off=1, send 'g' then 's' -> pwr_up 0->1->0; send 8'h00 in OFF -> no change.
//   8-cycle low glitch on idle RX -> no rdy, rx_data unchanged, FSM back in IDLE.
//   Assert RST_n=0 mid-byte (after bit 3) -> all outputs 0 immediately; next full
//     frame 8'h3C received correctly.
//   FRAME_CHK_EN: send 8'h55 with stop bit forced 0 -> frm_err 1-cycle pulse,
//     rdy stays 0; without macro -> rx_data=8'h55, rdy=1.

Source files
------------

// File: rtl/uart_cmd_rcv_if.sv
// rtl/uart_cmd_rcv_if.sv - signal bundle between the rider command link and power control
interface uart_cmd_rcv_if;
   logic       RX;
   logic       clr_rdy;
   logic       rider_off;
   logic [7:0] rx_data;
   logic       rdy;
   logic       pwr_up;
   logic       frm_err;

   modport slave  (input  RX, clr_rdy, rider_off, output rx_data, rdy, pwr_up, frm_err);
   modport master (output RX, clr_rdy, rider_off, input  rx_data, rdy, pwr_up, frm_err);
endinterface

// File: rtl/uart_cmd_rcv.sv
// rtl/uart_cmd_rcv.sv - 8N1 UART receiver feeding the rider power-authorization FSM
// Define FRAME_CHK_EN to reject frames with a bad stop bit and pulse frm_err.
module uart_cmd_rcv #(
   parameter int         BAUD_DIV = 2604,
   parameter logic [7:0] GO_CMD   = 8'h67,
   parameter logic [7:0] STOP_CMD = 8'h73
) (
   input logic           clk,
   input logic           RST_n,
   uart_cmd_rcv_if.slave bus
);
   localparam int            CW      = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] HALF_LD = CW'(BAUD_DIV / 2 - 1);
   localparam logic [CW-1:0] FULL_LD = CW'(BAUD_DIV - 1);

   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_RECV, RX_STOP, RX_WAIT_HI} rx_state_t;
   typedef enum logic [1:0] {AUTH_OFF, AUTH_ON, AUTH_PEND_OFF} auth_state_t;

   logic          r_rx_ff1;
   logic          r_rx_s;
   rx_state_t     r_rx_state;
   logic [CW-1:0] r_baud_cnt;
   logic [3:0]    r_bit_cnt;
   logic [7:0]    r_shift;
   logic [7:0]    r_rx_data;
   logic          r_byte_done;
   logic          r_rdy;
   auth_state_t   r_auth;
   logic          r_pwr_up;
   logic          w_baud_tick;
   logic          w_byte_vld;
   logic          w_start;

   assign w_baud_tick = (r_baud_cnt == '0);
   assign w_byte_vld  = r_byte_done;
   assign w_start     = (r_rx_state == RX_IDLE) && !r_rx_s;

   // RX is asynchronous; only the second flop is ever looked at.
   always_ff @(posedge clk or negedge RST_n) begin
      if (!RST_n) begin
         r_rx_ff1 <= 1'b1;
         r_rx_s   <= 1'b1;
      end else begin
         r_rx_ff1 <= bus.RX;
         r_rx_s   <= r_rx_ff1;
      end
   end

`ifdef FRAME_CHK_EN
   logic r_frm_err;
   always_ff @(posedge clk or negedge RST_n) begin
      if (!RST_n) r_frm_err <= 1'b0;
      else        r_frm_err <= (r_rx_state == RX_STOP) && w_baud_tick && !r_rx_s;
   end
   assign bus.frm_err = r_frm_err;
`else
   assign bus.frm_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge RST_n) begin
      if (!RST_n) begin
         r_rx_state  <= RX_IDLE;
         r_baud_cnt  <= '0;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_rx_data   <= '0;
         r_byte_done <= 1'b0;
      end else begin
         r_byte_done <= 1'b0;
         case (r_rx_state)
            RX_IDLE: begin
               if (!r_rx_s) begin
                  r_rx_state <= RX_START;
                  r_baud_cnt <= HALF_LD;
                  r_bit_cnt  <= '0;
               end
            end
            RX_START: begin
               if (!w_baud_tick) begin
                  r_baud_cnt <= r_baud_cnt - 1'b1;
               end else if (r_rx_s) begin
                  r_rx_state <= RX_IDLE;
               end else begin
                  r_rx_state <= RX_RECV;
                  r_baud_cnt <= FULL_LD;
               end
            end
            RX_RECV: begin
               if (!w_baud_tick) begin
                  r_baud_cnt <= r_baud_cnt - 1'b1;
               end else begin
                  r_shift    <= {r_rx_s, r_shift[7:1]};
                  r_bit_cnt  <= r_bit_cnt + 1'b1;
                  r_baud_cnt <= FULL_LD;
                  if (r_bit_cnt == 4'd7) r_rx_state <= RX_STOP;
               end
            end
            RX_STOP: begin
               if (!w_baud_tick) begin
                  r_baud_cnt <= r_baud_cnt - 1'b1;
`ifdef FRAME_CHK_EN
               end else if (!r_rx_s) begin
                  r_rx_state <= RX_WAIT_HI;
`endif
               end else begin
                  r_rx_data   <= r_shift;
                  r_byte_done <= 1'b1;
                  r_rx_state  <= RX_IDLE;
               end
            end
            RX_WAIT_HI: if (r_rx_s) r_rx_state <= RX_IDLE;
            default:    r_rx_state <= RX_IDLE;
         endcase
      end
   end

   // A completing frame beats a simultaneous clear.
   always_ff @(posedge clk or negedge RST_n) begin
      if (!RST_n)                       r_rdy <= 1'b0;
      else if (w_byte_vld)              r_rdy <= 1'b1;
      else if (bus.clr_rdy || w_start)  r_rdy <= 1'b0;
   end

   always_ff @(posedge clk or negedge RST_n) begin
      if (!RST_n) begin
         r_auth   <= AUTH_OFF;
         r_pwr_up <= 1'b0;
      end else begin
         case (r_auth)
            AUTH_OFF: begin
               if (w_byte_vld && r_rx_data == GO_CMD) begin
                  r_auth   <= AUTH_ON;
                  r_pwr_up <= 1'b1;
               end
            end
            AUTH_ON: begin
               if (w_byte_vld && r_rx_data == STOP_CMD) begin
                  r_auth   <= bus.rider_off ? AUTH_OFF : AUTH_PEND_OFF;
                  r_pwr_up <= !bus.rider_off;
               end
            end
            AUTH_PEND_OFF: begin
               if (bus.rider_off) begin
                  r_auth   <= AUTH_OFF;
                  r_pwr_up <= 1'b0;
               end else if (w_byte_vld && r_rx_data == GO_CMD) begin
                  r_auth   <= AUTH_ON;
                  r_pwr_up <= 1'b1;
               end
            end
            default: begin
               r_auth   <= AUTH_OFF;
               r_pwr_up <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rx_data = r_rx_data;
   assign bus.rdy     = r_rdy;
   assign bus.pwr_up  = r_pwr_up;
endmodule

// File: tb/tb_uart_cmd_rcv.sv
// tb/tb_uart_cmd_rcv.sv - self-checking bench for uart_cmd_rcv at BAUD_DIV=32
module tb_uart_cmd_rcv;
   localparam int         BD   = 32;
   localparam logic [7:0] GO   = 8'h67;
   localparam logic [7:0] STOP = 8'h73;

   logic clk = 1'b0;
   logic RST_n;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   int   start_cyc = 0;
   int   rise_cyc = 0;
   int   n_rise = 0;
   int   n_frm = 0;
   logic prev_rdy = 1'b0;
   logic [7:0] last_data;

   uart_cmd_rcv_if bus ();

   uart_cmd_rcv #(.BAUD_DIV(BD), .GO_CMD(GO), .STOP_CMD(STOP)) dut (
      .clk   (clk),
      .RST_n (RST_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.rdy && !prev_rdy) begin
         rise_cyc <= cyc;
         n_rise   <= n_rise + 1;
      end
      prev_rdy <= bus.rdy;
      if (bus.frm_err) n_frm <= n_frm + 1;
   end

   typedef struct {
      logic [7:0] data;
      bit         ro;
      bit         exp_pwr;
   } vec_t;
   vec_t tbl [12];

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic chk_rng(input string name, input int act, input int lo, input int hi);
      n_chk++;
      if (act >= lo && act <= hi) n_pass++;
      else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
   endtask

   task automatic send(input logic [7:0] b, input bit stop_bit);
      bus.RX = 1'b0;
      start_cyc = cyc;
      tick(BD);
      for (int i = 0; i < 8; i++) begin
         bus.RX = b[i];
         tick(BD);
      end
      bus.RX = stop_bit;
      tick(BD);
      bus.RX = 1'b1;
      tick(8);
   endtask

   task automatic do_frame(input string name, input logic [7:0] b, input bit exp_pwr);
      int nr;
      nr = n_rise;
      send(b, 1'b1);
      chk({name, "_rdy_rise"}, n_rise - nr, 1);
      chk_rng({name, "_latency"}, rise_cyc - start_cyc, 9 * BD + BD / 2 - 4, 9 * BD + BD / 2 + 4);
      chk({name, "_rx_data"}, bus.rx_data, b);
      chk({name, "_rdy"}, bus.rdy, 1);
      chk({name, "_pwr_up"}, bus.pwr_up, exp_pwr);
      last_data = b;
      bus.clr_rdy = 1'b1;
      tick(1);
      bus.clr_rdy = 1'b0;
      chk({name, "_rdy_clr"}, bus.rdy, 0);
   endtask

   initial begin
      int         m_state;
      bit         ro;
      logic [7:0] b;

      tbl[0]  = '{8'hA5, 1'b0, 1'b0};
      tbl[1]  = '{GO,    1'b0, 1'b1};
      tbl[2]  = '{STOP,  1'b0, 1'b1};
      tbl[3]  = '{GO,    1'b1, 1'b1};
      tbl[4]  = '{STOP,  1'b1, 1'b0};
      tbl[5]  = '{8'h00, 1'b1, 1'b0};
      tbl[6]  = '{STOP,  1'b0, 1'b0};
      tbl[7]  = '{GO,    1'b0, 1'b1};
      tbl[8]  = '{8'h55, 1'b0, 1'b1};
      tbl[9]  = '{STOP,  1'b0, 1'b1};
      tbl[10] = '{GO,    1'b0, 1'b1};
      tbl[11] = '{STOP,  1'b1, 1'b0};

      RST_n = 1'b0;
      bus.RX = 1'b1;
      bus.clr_rdy = 1'b0;
      bus.rider_off = 1'b0;
      tick(3);
      chk("rst_rx_data", bus.rx_data, 0);
      chk("rst_rdy", bus.rdy, 0);
      chk("rst_pwr_up", bus.pwr_up, 0);
      chk("rst_frm_err", bus.frm_err, 0);
      RST_n = 1'b1;
      tick(4);

      for (int i = 0; i < 12; i++) begin
         bus.rider_off = tbl[i].ro;
         tick(2);
         do_frame($sformatf("tbl%0d", i), tbl[i].data, tbl[i].exp_pwr);
         if (i == 2) begin
            chk("pend_hold", bus.pwr_up, 1);
            bus.rider_off = 1'b1;
            tick(1);
            chk("pend_stepoff", bus.pwr_up, 0);
         end
      end

      // Short low glitch must not start a frame.
      begin
         int nr;
         nr = n_rise;
         bus.RX = 1'b0;
         tick(8);
         bus.RX = 1'b1;
         tick(40);
         chk("glitch_no_rdy", n_rise - nr, 0);
         chk("glitch_rdy", bus.rdy, 0);
         chk("glitch_rx_data", bus.rx_data, last_data);
         do_frame("post_glitch", 8'h5A, 1'b0);
      end

      // Reset in the middle of a byte.
      bus.rider_off = 1'b0;
      tick(2);
      do_frame("pre_rst_go", GO, 1'b1);
      bus.RX = 1'b0;
      tick(BD);
      for (int i = 0; i < 4; i++) begin
         bus.RX = i[0];
         tick(BD);
      end
      RST_n = 1'b0;
      #2;
      chk("midrst_rx_data", bus.rx_data, 0);
      chk("midrst_rdy", bus.rdy, 0);
      chk("midrst_pwr_up", bus.pwr_up, 0);
      chk("midrst_frm_err", bus.frm_err, 0);
      bus.RX = 1'b1;
      tick(3);
      RST_n = 1'b1;
      tick(40);
      do_frame("post_rst", 8'h3C, 1'b0);

      // Random traffic against a byte-level authorization model.
      m_state = 0;
      for (int n = 0; n < 20; n++) begin
         ro = 1'($urandom_range(0, 1));
         bus.rider_off = ro;
         if (m_state == 2 && ro) m_state = 0;
         tick(2);
         chk($sformatf("rnd%0d_pre_pwr", n), bus.pwr_up, (m_state != 0));
         case ($urandom_range(0, 3))
            0:       b = GO;
            1:       b = STOP;
            default: b = 8'($urandom_range(0, 255));
         endcase
         if (m_state == 0 && b == GO)        m_state = 1;
         else if (m_state == 1 && b == STOP) m_state = ro ? 0 : 2;
         else if (m_state == 2 && b == GO)   m_state = 1;
         do_frame($sformatf("rnd%0d", n), b, (m_state != 0));
      end

      // Stop bit forced low.
      begin
         int nr;
         int nf;
         nr = n_rise;
         nf = n_frm;
         send(8'h55, 1'b0);
         tick(4);
`ifdef FRAME_CHK_EN
         chk("badstop_frm_err", n_frm - nf, 1);
         chk("badstop_no_rdy", n_rise - nr, 0);
         chk("badstop_rdy", bus.rdy, 0);
         chk("badstop_rx_data", bus.rx_data, last_data);
`else
         chk("badstop_frm_err", n_frm - nf, 0);
         chk("badstop_rdy_rise", n_rise - nr, 1);
         chk("badstop_rdy", bus.rdy, 1);
         chk("badstop_rx_data", bus.rx_data, 8'h55);
`endif
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
